// File: rtl/i2c_sched_pkg.sv
// Shared definitions for the I2C configuration scheduler.
//   I2C_FRAME_BITS   : bit-ticks the 4-byte transmitter spends shifting one frame
//   sched_state_t    : scheduler FSM states
//   DEF_*            : default tick constants for the top-level parameters
package i2c_sched_pkg;

  localparam int I2C_FRAME_BITS  = 168;

  localparam int DEF_DIV_LOG2    = 15;
  localparam int DEF_HOLD_TICKS  = 4;
  // 168 shift ticks plus 8 guard ticks before the next ENABLE may rise.
  localparam int DEF_FRAME_TICKS = I2C_FRAME_BITS + 8;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_ASSERT,
    ST_SHIFT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-input round-robin arbiter (purely combinational).
//   valid_i : request valid per requester
//   ptr_i   : requester favoured when both are valid (0 or 1)
//   grant_o : one-hot grant, or zero when nothing is valid
module i2c_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    unique case (valid_i)
      2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
      default: grant_o = valid_i;  // 00, 01, 10 are already zero or one-hot
    endcase
  end

endmodule

// File: rtl/i2c_cfg_scheduler.sv
// Shares one 4-byte brute-force I2C transmitter between two configuration
// requesters. Round-robin grant in IDLE, latches the winning word and bus
// mask, pulses ENABLE for the hold window and times the frame by counting,
// since the transmitter reports no busy/done.
//   CLK, RESET             : clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY    : per-requester handshake (READY one-hot or zero)
//   REQ_LINES, REQ_DATA    : per-requester bus mask and 32-bit word
//   REQ_DONE               : one-cycle completion pulse to the owner
//   ENABLE, I2CLINES,
//   I2CDATA12, I2CDATA34   : transmitter controls
//   BUSY                   : high in every state except IDLE
module i2c_cfg_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int DIV_LOG2    = DEF_DIV_LOG2,
  parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [3:0]  REQ_LINES,
  input  logic [63:0] REQ_DATA,
  output logic [1:0]  REQ_DONE,
  output logic        ENABLE,
  output logic [1:0]  I2CLINES,
  output logic [15:0] I2CDATA12,
  output logic [15:0] I2CDATA34,
  output logic        BUSY
);

  localparam int SLOT      = (HOLD_TICKS + FRAME_TICKS) << DIV_LOG2;
  localparam int HOLD_CYC  = HOLD_TICKS << DIV_LOG2;
  localparam int FRAME_CYC = FRAME_TICKS << DIV_LOG2;
  localparam int CW        = $clog2(SLOT + 1);

  // Counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [CW-1:0] SLOT_LD  = CW'(SLOT - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] FRAME_LD = CW'(FRAME_CYC - 1);

  sched_state_t   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     lines_q, lines_d;
  logic [31:0]    data_q, data_d;
  logic           owner_q, owner_d;
  logic           ptr_q, ptr_d;

  logic [1:0]     grant;
  logic           win;
  logic [1:0]     win_lines;
  logic [31:0]    win_data;
  logic           drive;

  i2c_rr_arb2 u_arb (
    .valid_i (REQ_VALID),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign REQ_READY = (state_q == ST_IDLE) ? grant : 2'b00;
  assign win       = REQ_READY[1];
  assign win_lines = win ? REQ_LINES[3:2] : REQ_LINES[1:0];
  assign win_data  = win ? REQ_DATA[63:32] : REQ_DATA[31:0];

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      ST_STARTUP: begin
        // A frame left over from before reset may still be shifting out.
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (|REQ_READY) begin
          lines_d = win_lines;
          data_d  = win_data;
          owner_d = win;
          ptr_d   = ~win;
          if (win_lines == 2'b00) begin
            state_d = ST_DONE;  // no bus selected: complete without a frame
          end else begin
            state_d = ST_ASSERT;
            cnt_d   = HOLD_LD;
          end
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          cnt_d   = FRAME_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_STARTUP;
        cnt_d   = SLOT_LD;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_STARTUP;
      cnt_q   <= SLOT_LD;
      lines_q <= 2'b00;
      // NOTE: the word latch is reset as well, because it drives I2CDATA* directly.
      data_q  <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decode the state register, so reset clears ENABLE/I2CLINES at once.
  assign drive     = (state_q == ST_ASSERT) || (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign ENABLE    = (state_q == ST_ASSERT);
  assign I2CLINES  = drive ? lines_q : 2'b00;
  assign I2CDATA12 = data_q[31:16];
  assign I2CDATA34 = data_q[15:0];
  assign REQ_DONE  = (state_q != ST_DONE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_cfg_scheduler.sv
// Self-checking bench for i2c_cfg_scheduler with DIV_LOG2=2 (hold 16 cycles,
// slot 720 cycles). A table of requests is run back to back after reset,
// followed by a hand-written reset-in-SHIFT sequence.
module tb_i2c_cfg_scheduler;

  localparam int DIV_LOG2   = 2;
  localparam int HOLD_CYC   = 16;
  localparam int SLOT       = 720;
  localparam int WAIT_LIMIT = 2000;
  localparam int NV         = 6;

  logic        CLK;
  logic        RESET;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  logic [3:0]  REQ_LINES;
  logic [63:0] REQ_DATA;
  logic [1:0]  REQ_DONE;
  logic        ENABLE;
  logic [1:0]  I2CLINES;
  logic [15:0] I2CDATA12;
  logic [15:0] I2CDATA34;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  lines;
    logic [63:0] data;
    logic        drop;       // deassert REQ_VALID the cycle after acceptance
    int          exp_wait;   // cycles until REQ_READY rises
    logic [1:0]  exp_ready;
    logic [1:0]  exp_lines;
    logic [15:0] exp_d12;
    logic [15:0] exp_d34;
    logic        framed;     // ENABLE expected to pulse
    logic [1:0]  exp_done;
  } vec_t;

  vec_t vecs [NV];

  i2c_cfg_scheduler #(
    .DIV_LOG2    (DIV_LOG2),
    .HOLD_TICKS  (4),
    .FRAME_TICKS (176)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_LINES (REQ_LINES),
    .REQ_DATA  (REQ_DATA),
    .REQ_DONE  (REQ_DONE),
    .ENABLE    (ENABLE),
    .I2CLINES  (I2CLINES),
    .I2CDATA12 (I2CDATA12),
    .I2CDATA34 (I2CDATA34),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v);
    REQ_VALID = v.valid;
    REQ_LINES = v.lines;
    REQ_DATA  = v.data;
  endtask

  // Counts cycles until REQ_READY rises; buses must stay quiet meanwhile.
  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (REQ_READY == 2'b00 && n < WAIT_LIMIT) begin
      check({tag, "_wait_lines"}, I2CLINES, 2'b00);
      check({tag, "_wait_enable"}, ENABLE, 1'b0);
      check({tag, "_wait_done"}, REQ_DONE, 2'b00);
      tick();
      n++;
    end
  endtask

  // Called in the acceptance cycle; returns in the REQ_DONE cycle.
  task automatic run_frame(input int idx, input vec_t v);
    int done_off;
    string t;
    done_off = v.framed ? SLOT + 1 : 1;
    for (int k = 1; k <= done_off; k++) begin
      tick();
      if (v.drop && k == 1) begin
        REQ_VALID = 2'b00;
        #1;
      end
      t = $sformatf("v%0d_k%0d", idx, k);
      check({t, "_enable"}, ENABLE, v.framed && (k <= HOLD_CYC));
      check({t, "_done"}, REQ_DONE, (k == done_off) ? v.exp_done : 2'b00);
      check({t, "_lines"}, I2CLINES, v.exp_lines);
      check({t, "_d12"}, I2CDATA12, v.exp_d12);
      check({t, "_d34"}, I2CDATA34, v.exp_d34);
      check({t, "_busy"}, BUSY, 1'b1);
      check({t, "_ready"}, REQ_READY, 2'b00);
    end
  endtask

  initial begin
    int n;
    string t;

    //                valid  lines    data                     drop wait exp_rdy lines  d12      d34      framed done
    vecs[0] = '{2'b01, 4'b0010, 64'h0000_0000_A5C3_1234, 1'b1, SLOT, 2'b01, 2'b10, 16'hA5C3, 16'h1234, 1'b1, 2'b01};
    vecs[1] = '{2'b11, 4'b0111, 64'h1111_2222_3333_4444, 1'b0, 0,    2'b10, 2'b01, 16'h1111, 16'h2222, 1'b1, 2'b10};
    vecs[2] = '{2'b11, 4'b0111, 64'h1111_2222_3333_4444, 1'b0, 0,    2'b01, 2'b11, 16'h3333, 16'h4444, 1'b1, 2'b01};
    vecs[3] = '{2'b11, 4'b0111, 64'h1111_2222_3333_4444, 1'b0, 0,    2'b10, 2'b01, 16'h1111, 16'h2222, 1'b1, 2'b10};
    vecs[4] = '{2'b10, 4'b0011, 64'hDEAD_BEEF_5555_AAAA, 1'b0, 0,    2'b10, 2'b00, 16'hDEAD, 16'hBEEF, 1'b0, 2'b10};
    vecs[5] = '{2'b11, 4'b1001, 64'h7777_8888_0F0F_F0F0, 1'b1, 0,    2'b01, 2'b01, 16'h0F0F, 16'hF0F0, 1'b1, 2'b01};

    RESET = 1'b1;
    apply(vecs[0]);
    repeat (3) tick();
    check("rst_enable", ENABLE, 1'b0);
    check("rst_lines", I2CLINES, 2'b00);
    check("rst_d12", I2CDATA12, 16'h0000);
    check("rst_d34", I2CDATA34, 16'h0000);
    check("rst_ready", REQ_READY, 2'b00);
    check("rst_done", REQ_DONE, 2'b00);
    check("rst_busy", BUSY, 1'b1);
    RESET = 1'b0;
    #1;

    for (int i = 0; i < NV; i++) begin
      t = $sformatf("v%0d", i);
      if (i > 0) begin
        apply(vecs[i]);
        #1;
      end
      wait_ready(t, n);
      check({t, "_wait_cycles"}, n, vecs[i].exp_wait);
      check({t, "_ready"}, REQ_READY, vecs[i].exp_ready);
      run_frame(i, vecs[i]);
      tick();
      check({t, "_idle_busy"}, BUSY, 1'b0);
      check({t, "_idle_lines"}, I2CLINES, 2'b00);
      check({t, "_idle_done"}, REQ_DONE, 2'b00);
    end

    // Reset 100 cycles into SHIFT of a requester-0 frame on both buses.
    REQ_VALID = 2'b01;
    REQ_LINES = 4'b0011;
    REQ_DATA  = 64'h0000_0000_1357_9BDF;
    #1;
    check("ab_ready", REQ_READY, 2'b01);
    for (int k = 1; k <= HOLD_CYC + 100; k++) begin
      tick();
      if (k == 1) REQ_VALID = 2'b00;
    end
    check("ab_pre_lines", I2CLINES, 2'b11);
    check("ab_pre_d12", I2CDATA12, 16'h1357);
    RESET = 1'b1;
    #1;
    check("ab_enable", ENABLE, 1'b0);
    check("ab_lines", I2CLINES, 2'b00);
    check("ab_done", REQ_DONE, 2'b00);
    check("ab_busy", BUSY, 1'b1);
    check("ab_d12", I2CDATA12, 16'h0000);
    repeat (3) begin
      tick();
      check("ab_hold_done", REQ_DONE, 2'b00);
    end
    // Both valid: a reset pointer must favour requester 0 again.
    REQ_VALID = 2'b11;
    REQ_LINES = 4'b1001;
    REQ_DATA  = 64'h2468_ACE0_1357_9BDF;
    RESET = 1'b0;
    #1;
    wait_ready("ab", n);
    check("ab_wait_cycles", n, SLOT);
    check("ab_ptr_ready", REQ_READY, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/i2c_cfg_scheduler.md
# i2c_cfg_scheduler

Sequences and shares the 4-byte brute-force I2C transmitter (`I2C4BYTES`) between two configuration requesters, such as the ESP32 command path and the power-on defaults loader.
- Arbitrates round-robin and latches the winning 32-bit word and bus mask.
- Generates the transmitter's `ENABLE` pulse and holds data and lines stable for a whole frame slot.
- The transmitter has no busy output, so frame completion is derived from a matched cycle count.

## Interface
Parameters:
- `DIV_LOG2`, 15 — transmitter bit-tick = 2^DIV_LOG2 CLK cycles; must match the transmitter's divider.
- `HOLD_TICKS`, 4 — ticks `ENABLE` stays high; must be ≥3 to guarantee edge capture.
- `FRAME_TICKS`, 176 — ticks `ENABLE` stays low after the hold: 168 shift plus 8 guard.

Ports:
- `CLK`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ_VALID`  in  2  per-requester request valid.
- `REQ_READY`  out  2  per-requester accept; one-hot or zero.
- `REQ_LINES`  in  2×2  per-requester bus mask (`[1:0]` for requester 0, `[3:2]` for requester 1).
- `REQ_DATA`  in  2×32  per-requester word (`[31:0]` for requester 0, `[63:32]` for requester 1); bits [31:16] drive `I2CDATA12`, bits [15:0] drive `I2CDATA34`.
- `REQ_DONE`  out  2  one-cycle completion pulse to the owning requester.
- `ENABLE`  out  1  transmitter start.
- `I2CLINES`  out  2  transmitter bus select.
- `I2CDATA12`  out  16  transmitter bytes 1–2.
- `I2CDATA34`  out  16  transmitter bytes 3–4.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- States: STARTUP, IDLE, ASSERT, SHIFT, DONE.
- STARTUP:
  - Entered on reset. The transmitter has no reset, so a frame may still be shifting.
  - Waits one full slot of `SLOT = (HOLD_TICKS+FRAME_TICKS)<<DIV_LOG2` cycles, then goes to IDLE.
- IDLE:
  - Grant is combinational. `REQ_READY` is asserted to the winner among `REQ_VALID`.
  - If both are valid, the requester not served last wins. The pointer resets to favour requester 0.
  - On `REQ_VALID&REQ_READY`, the winner's lines and data are latched, the owner is recorded and the pointer updates.
  - Next state is ASSERT, or DONE if the latched mask is 2'b00. A zero mask emits no frame.
- ASSERT:
  - `ENABLE`=1 for `HOLD_TICKS<<DIV_LOG2` cycles, then SHIFT.
- SHIFT:
  - `ENABLE`=0 for `FRAME_TICKS<<DIV_LOG2` cycles, then DONE.
- DONE:
  - `REQ_DONE[owner]` is pulsed for one cycle, then IDLE.
- `I2CLINES`, `I2CDATA12` and `I2CDATA34` come from the latch.
  - They are stable from ASSERT entry through DONE.
  - `I2CLINES` is forced to 0 in STARTUP and IDLE so idle buses are not driven.
- A single down-counter serves all timed states. Width is `$clog2(SLOT+1)`, and no arithmetic wraps.
- `REQ_VALID` dropping after acceptance has no effect. Requester inputs are ignored outside IDLE.

## Timing
- Reset values:
  - `ENABLE`=0, `I2CLINES`=0, `I2CDATA12`=0, `I2CDATA34`=0.
  - `REQ_READY`=0, `REQ_DONE`=0, `BUSY`=1.
  - State is STARTUP and the pointer favours requester 0.
- Reset asserted mid-frame: `ENABLE` and `I2CLINES` go to 0 asynchronously and STARTUP restarts. No `REQ_DONE` is issued for the aborted request.
- Acceptance edge to `ENABLE` rising: 1 cycle.
- Acceptance edge to `REQ_DONE` pulse: `1 + SLOT` cycles.
- Back-to-back requests: the earliest next acceptance is the cycle after `REQ_DONE`, in IDLE. Minimum request period is `SLOT+2` cycles.
- Zero-mask request: `REQ_DONE` 1 cycle after acceptance, with no `ENABLE`.
- A request arriving during STARTUP waits until IDLE.

## Structure
- Package `i2c_sched_pkg` holds:
  - `I2C_FRAME_BITS` = 168.
  - The state enum `sched_state_t`.
  - Default tick constants.
- Sub-module `i2c_rr_arb2` is a two-input round-robin arbiter. It takes valid and pointer and returns a one-hot grant.
- The FSM, counter and latch live in the top level.

## Test plan
- DIV_LOG2=2 throughout, giving a hold of 16 cycles and SLOT=720.
- Reset release with `REQ_VALID`=01 → `REQ_READY` stays 0 for 720 cycles, then is asserted. `I2CLINES` stays 0 throughout.
- Single request, requester 0, data 0xA5C3_1234, lines 10:
  - `ENABLE` is high cycles 1–16 after acceptance.
  - `I2CDATA12`=0xA5C3 and `I2CDATA34`=0x1234 hold through SHIFT.
  - `REQ_DONE`=01 at acceptance+721.
- `REQ_VALID`=11 held continuously → grants alternate 01, 10, 01, spaced 722 cycles apart.
- Requester 1 with lines 00 → `REQ_DONE`=10 one cycle after acceptance; `ENABLE` never rises.
- `RESET` pulsed 100 cycles into SHIFT:
  - `ENABLE`=0 and `I2CLINES`=0 immediately.
  - No `REQ_DONE` is issued.
  - The next grant comes only after 720 STARTUP cycles.
- `REQ_VALID` dropped the cycle after acceptance → the frame completes normally and `REQ_DONE` still pulses.
